// File: rtl/snake_motion_controller_if.sv
// Bundle between the snake motion controller and the game/display side.
// Carries tick/direction/apple/draw_busy in, body arrays and status out.
interface snake_motion_controller_if #(
  parameter int MAX_LEN = 128
);
  logic                   tick;
  logic [3:0]             direction;
  logic [7:0]             appleX;
  logic [8:0]             appleY;
  logic                   draw_busy;
  logic [8*MAX_LEN-1:0]   snakeX;
  logic [9*MAX_LEN-1:0]   snakeY;
  logic [7:0]             length;
  logic                   gameOver;
  logic                   apple_eaten;
  logic                   update_done;
  logic                   busy;

  modport master (
    output tick, direction, appleX, appleY, draw_busy,
    input  snakeX, snakeY, length, gameOver,
    input  apple_eaten, update_done, busy
  );

  modport slave (
    input  tick, direction, appleX, appleY, draw_busy,
    output snakeX, snakeY, length, gameOver,
    output apple_eaten, update_done, busy
  );
endinterface

// File: rtl/snake_motion_controller.sv
// Snake head/body sequencer: move, wall check, serial self-scan, commit.
// Define SNAKE_WRAP_EN to make walls wrap instead of ending the game.
module snake_motion_controller #(
  parameter int MAX_LEN = 128,
  parameter int STEP    = 10,
  parameter int XMAX    = 230,
  parameter int YMAX    = 310,
  parameter int START_X = 40,
  parameter int START_Y = 30
) (
  input  logic clock,
  input  logic reset,
  snake_motion_controller_if.slave bus
);

  localparam int IW = $clog2(MAX_LEN);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_MOVE   = 3'd2;
  localparam logic [2:0] S_SCAN   = 3'd3;
  localparam logic [2:0] S_COMMIT = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_OVER   = 3'd6;

`ifdef SNAKE_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic [2:0]    state;
  logic [3:0]    dir;
  logic [7:0]    len;
  logic [7:0]    seg_x [MAX_LEN];
  logic [8:0]    seg_y [MAX_LEN];
  logic [7:0]    new_x;
  logic [8:0]    new_y;
  logic          grow;
  logic [IW-1:0] idx;
  logic [IW-1:0] last;

  logic [3:0]    dir_rev;
  logic          dir_ok;
  logic [8:0]    px;
  logic [9:0]    py;
  logic [7:0]    nx;
  logic [8:0]    ny;
  logic          hit;
  logic          wall;
  logic          eat;
  logic          keep;

  assign dir_rev = {dir[2], dir[3], dir[0], dir[1]};
  assign dir_ok  = $onehot(bus.direction)
                && (bus.direction != dir_rev);

  assign px = {1'b0, seg_x[0]} + 9'(STEP);
  assign py = {1'b0, seg_y[0]} + 10'(STEP);

  // Candidate head; in wrap builds the wrapped value is used directly
  always_comb begin
    hit = 1'b0;
    nx  = seg_x[0];
    ny  = seg_y[0];
    unique case (1'b1)
      dir[0]: begin
        if (seg_x[0] < 8'(STEP)) begin
          hit = 1'b1;
          nx  = 8'(XMAX);
        end else begin
          nx  = seg_x[0] - 8'(STEP);
        end
      end
      dir[1]: begin
        if (px > 9'(XMAX)) begin
          hit = 1'b1;
          nx  = '0;
        end else begin
          nx  = px[7:0];
        end
      end
      dir[2]: begin
        if (seg_y[0] < 9'(STEP)) begin
          hit = 1'b1;
          ny  = 9'(YMAX);
        end else begin
          ny  = seg_y[0] - 9'(STEP);
        end
      end
      dir[3]: begin
        if (py > 10'(YMAX)) begin
          hit = 1'b1;
          ny  = '0;
        end else begin
          ny  = py[8:0];
        end
      end
      default: ;
    endcase
  end

  assign wall = hit && !WRAP;
  assign eat  = (nx == bus.appleX) && (ny == bus.appleY);
  assign keep = grow && (len < 8'(MAX_LEN));

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
      dir   <= 4'b0001;
      len   <= 8'd3;
      new_x <= '0;
      new_y <= '0;
      grow  <= 1'b0;
      idx   <= '0;
      last  <= '0;
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x[i] <= '0;
        seg_y[i] <= '0;
      end
      seg_x[0] <= 8'(START_X);
      seg_x[1] <= 8'(START_X + STEP);
      seg_x[2] <= 8'(START_X + 2 * STEP);
      seg_y[0] <= 9'(START_Y);
      seg_y[1] <= 9'(START_Y);
      seg_y[2] <= 9'(START_Y);
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.tick) begin
            state <= S_WAIT;
            if (dir_ok) dir <= bus.direction;
          end
        end
        S_WAIT: begin
          if (!bus.draw_busy) state <= S_MOVE;
        end
        S_MOVE: begin
          if (wall) begin
            state <= S_OVER;
          end else begin
            new_x <= nx;
            new_y <= ny;
            grow  <= eat;
            idx   <= '0;
            last  <= IW'(eat ? len - 8'd1 : len - 8'd2);
            state <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (seg_x[idx] == new_x && seg_y[idx] == new_y)
            state <= S_OVER;
          else if (idx == last)
            state <= S_COMMIT;
          else
            idx <= idx + 1'b1;
        end
        S_COMMIT: begin
          // Old tail lands at index len after the shift unless it grows
          for (int i = MAX_LEN - 1; i > 0; i--) begin
            seg_x[i] <= seg_x[i-1];
            seg_y[i] <= seg_y[i-1];
            if (!keep && i == int'(len)) begin
              seg_x[i] <= '0;
              seg_y[i] <= '0;
            end
          end
          seg_x[0] <= new_x;
          seg_y[0] <= new_y;
          if (keep) len <= len + 8'd1;
          state <= S_DONE;
        end
        S_DONE: state <= S_IDLE;
        S_OVER: ;
        default: state <= S_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < MAX_LEN; g++) begin : g_pack
    assign bus.snakeX[8*g +: 8] = seg_x[g];
    assign bus.snakeY[9*g +: 9] = seg_y[g];
  end

  assign bus.length      = len;
  assign bus.gameOver    = (state == S_OVER);
  assign bus.apple_eaten = (state == S_COMMIT) && grow;
  assign bus.update_done = (state == S_DONE);
  assign bus.busy        = (state != S_IDLE) && (state != S_OVER);

endmodule
